// File: rtl/ordenador_seq_pkg.sv
// Shared constants and types for the serial 8-word sorter.
package ordenador_seq_pkg;

    localparam int N_WORDS  = 8;
    localparam int N_PHASES = 8;
    localparam int CNT_W    = 3;
    localparam int SIZE     = 8;

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        SORT  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    typedef logic [SIZE-1:0] word_t;
    typedef word_t [N_WORDS-1:0] bank_t;

endpackage

// File: rtl/ordenador_seq_fase.sv
// One odd-even transposition phase over the 8-word bank, built from four
// compare-exchange cells whose operands are steered by the phase parity.
module ord_cx
    import ordenador_seq_pkg::*;
(
    input  word_t a,
    input  word_t b,
    output word_t lo,
    output word_t hi,
    output logic  swap
);

    // Strict compare so equal words never move.
    always_comb begin
        swap = (a > b);
        lo   = swap ? b : a;
        hi   = swap ? a : b;
    end

endmodule

module ord_fase
    import ordenador_seq_pkg::*;
(
    input  bank_t bank,
    input  logic  odd,
    output bank_t next_bank,
    output logic  any_swap
);

    word_t      ca [4];
    word_t      cb [4];
    word_t      cl [4];
    word_t      ch [4];
    logic [3:0] cs;

    // In odd phases the fourth cell sees bank[7] twice, so it never swaps.
    always_comb begin
        ca[0] = odd ? bank[1] : bank[0];
        cb[0] = odd ? bank[2] : bank[1];
        ca[1] = odd ? bank[3] : bank[2];
        cb[1] = odd ? bank[4] : bank[3];
        ca[2] = odd ? bank[5] : bank[4];
        cb[2] = odd ? bank[6] : bank[5];
        ca[3] = odd ? bank[7] : bank[6];
        cb[3] = bank[7];
    end

    for (genvar i = 0; i < 4; i++) begin : g_cx
        ord_cx u_cx (
            .a    (ca[i]),
            .b    (cb[i]),
            .lo   (cl[i]),
            .hi   (ch[i]),
            .swap (cs[i])
        );
    end

    always_comb begin
        next_bank = bank;
        if (odd) begin
            next_bank[1] = cl[0];
            next_bank[2] = ch[0];
            next_bank[3] = cl[1];
            next_bank[4] = ch[1];
            next_bank[5] = cl[2];
            next_bank[6] = ch[2];
        end else begin
            next_bank[0] = cl[0];
            next_bank[1] = ch[0];
            next_bank[2] = cl[1];
            next_bank[3] = ch[1];
            next_bank[4] = cl[2];
            next_bank[5] = ch[2];
            next_bank[6] = cl[3];
            next_bank[7] = ch[3];
        end
        any_swap = |cs;
    end

endmodule

// File: rtl/ordenador_seq.sv
// Serial load / sort / drain controller around ord_fase.
// ORD_EARLY_EXIT_EN: leave SORT after two consecutive phases without a swap.
module ordenador_seq
    import ordenador_seq_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [SIZE-1:0] in_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [SIZE-1:0] out_data,
    output logic            out_last,
    output logic            busy
);

    state_t             state;
    state_t             state_next;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   phase;
    bank_t              bank;
    bank_t              bank_phase;
    logic               any_swap;
    logic               accept;
    logic               take;
    logic               early_done;

    assign accept = in_valid && in_ready;
    assign take   = out_valid && out_ready;

    ord_fase u_fase (
        .bank      (bank),
        .odd       (phase[0]),
        .next_bank (bank_phase),
        .any_swap  (any_swap)
    );

`ifdef ORD_EARLY_EXIT_EN
    logic quiet;

    // quiet remembers that the previous phase of this sort made no swap.
    always_ff @(posedge clk) begin
        if (reset || state != SORT) begin
            quiet <= 1'b0;
        end else begin
            quiet <= !any_swap;
        end
    end

    assign early_done = quiet && !any_swap;
`else
    logic unused_any_swap;
    assign unused_any_swap = any_swap;
    assign early_done      = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= LOAD;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            LOAD:    if (accept && cnt == CNT_W'(N_WORDS - 1)) state_next = SORT;
            SORT:    if (phase == CNT_W'(N_PHASES - 1) || early_done) state_next = DRAIN;
            DRAIN:   if (take && cnt == CNT_W'(N_WORDS - 1)) state_next = LOAD;
            default: state_next = LOAD;
        endcase
    end

    always_comb begin
        in_ready  = (state == LOAD) && !reset;
        out_valid = (state == DRAIN) && !reset;
        busy      = (state == SORT) && !reset;
        out_data  = out_valid ? bank[cnt] : '0;
        out_last  = out_valid && (cnt == CNT_W'(N_WORDS - 1));
    end

    // cnt wraps from 7 to 0 on its own, which is exactly the restart value.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt   <= '0;
            phase <= '0;
            bank  <= '0;
        end else begin
            case (state)
                LOAD: begin
                    phase <= '0;
                    if (accept) begin
                        bank[cnt] <= in_data;
                        cnt       <= cnt + 1'b1;
                    end
                end
                SORT: begin
                    bank  <= bank_phase;
                    phase <= phase + 1'b1;
                    cnt   <= '0;
                end
                DRAIN: begin
                    if (take) cnt <= cnt + 1'b1;
                end
                default: begin
                    cnt   <= '0;
                    phase <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ordenador_seq.sv
// Randomized scoreboard bench for ordenador_seq; honours ORD_EARLY_EXIT_EN.
module tb_ordenador_seq;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] in_data = 8'd0;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic [7:0] out_data;
    logic       out_last;
    logic       busy;

    ordenador_seq dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] data;
        logic       last;
    } exp_t;

    exp_t       expQ[$];
    int         busyQ[$];
    logic [7:0] blk[8];
    int         cyc = 0;
    int         tests = 0;
    int         fails = 0;
    int         lastAccept = 0;
    int         readyMode = 0;
    int         patIdx = 0;

    always @(posedge clk) cyc = cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    // out_ready: 0 = always, 1 = random, 2 = repeating 1-0-0-1
    always @(posedge clk) begin
        #1;
        case (readyMode)
            0: out_ready = 1'b1;
            1: out_ready = 1'($urandom_range(0, 1));
            default: begin
                out_ready = (patIdx % 4 == 0) || (patIdx % 4 == 3);
                patIdx++;
            end
        endcase
    end

    // Monitor: pops the scoreboard on each output handshake and watches timing rules.
    int         busyLen = 0;
    bit         prevBusy = 0;
    bit         prevValid = 0;
    bit         prevStall = 0;
    bit         prevLastTake = 0;
    bit         prevReset = 1;
    int         lastBusyLen = 0;
    logic [7:0] heldData;
    logic       heldLast;

    always @(negedge clk) begin
        if (reset) begin
            checkOutput("rst_in_ready", in_ready, 0);
            checkOutput("rst_out_valid", out_valid, 0);
            checkOutput("rst_busy", busy, 0);
            checkOutput("rst_out_data", out_data, 0);
            checkOutput("rst_out_last", out_last, 0);
            busyLen = 0;
            prevBusy = 0;
            prevValid = 0;
            prevStall = 0;
            prevLastTake = 0;
            prevReset = 1;
        end else begin
            if (prevReset) checkOutput("in_ready_after_reset", in_ready, 1);
            if (busy || out_valid) checkOutput("in_ready_outside_load", in_ready, 0);
            if (prevLastTake) checkOutput("in_ready_after_last", in_ready, 1);

            if (busy) begin
                busyLen++;
            end else if (prevBusy) begin
                lastBusyLen = busyLen;
                if (busyQ.size() == 0) begin
                    checkOutput("busy_unexpected", 1, 0);
                end else begin
                    int eb;
                    eb = busyQ.pop_front();
                    if (eb == 0) checkOutput("busy_range", (busyLen >= 2 && busyLen <= 8), 1);
                    else         checkOutput("busy_len", busyLen, eb);
                end
                busyLen = 0;
            end

            if (out_valid && !prevValid)
                checkOutput("first_valid_latency", cyc - lastAccept, lastBusyLen + 1);

            if (prevStall && out_valid) begin
                checkOutput("stall_data", out_data, heldData);
                checkOutput("stall_last", out_last, heldLast);
            end

            if (out_valid && out_ready) begin
                if (expQ.size() == 0) begin
                    checkOutput("unexpected_output", 1, 0);
                end else begin
                    exp_t e;
                    e = expQ.pop_front();
                    checkOutput("out_data", out_data, e.data);
                    checkOutput("out_last", out_last, e.last);
                end
            end

            prevBusy     = busy;
            prevValid    = out_valid;
            prevStall    = out_valid && !out_ready;
            prevLastTake = out_valid && out_ready && out_last;
            heldData     = out_data;
            heldLast     = out_last;
            prevReset    = 0;
        end
    end

    task automatic sendWord(input logic [7:0] w, output int accCycle);
        bit done;
        done = 0;
        in_valid = 1'b1;
        in_data  = w;
        for (int k = 0; k < 300 && !done; k++) begin
            @(negedge clk);
            if (in_ready) begin
                accCycle = cyc;
                done = 1;
            end
            @(posedge clk);
            #1;
        end
        if (!done) checkOutput("in_ready_timeout", 0, 1);
        in_valid = 1'b0;
    endtask

    // Sends nWords of blk; a full block also pushes its sorted expectation.
    task automatic applyStimulus(input int nWords, input bit hold);
        int         acc;
        logic [7:0] q[$];
        bit         ascending;
        bit         done;
        for (int i = 0; i < nWords; i++) begin
            sendWord(blk[i], acc);
            if (i == 7) lastAccept = acc;
            if (!hold && i < 7) repeat ($urandom_range(0, 2)) @(posedge clk);
            #0;
        end
        if (nWords == 8) begin
            q = {};
            ascending = 1;
            for (int i = 0; i < 8; i++) begin
                q.push_back(blk[i]);
                if (i > 0 && blk[i-1] > blk[i]) ascending = 0;
            end
            q.sort();
            for (int i = 0; i < 8; i++) expQ.push_back('{data: q[i], last: (i == 7)});
`ifdef ORD_EARLY_EXIT_EN
            busyQ.push_back(ascending ? 2 : 0);
`else
            busyQ.push_back(8);
`endif
        end
        if (hold) begin
            done = 0;
            in_valid = 1'b1;
            for (int k = 0; k < 200 && !done; k++) begin
                in_data = 8'($urandom);
                @(negedge clk);
                if (out_valid && out_ready && out_last) done = 1;
                @(posedge clk);
                #1;
            end
            if (!done) checkOutput("drain_timeout", 0, 1);
            in_valid = 1'b0;
        end
    endtask

    task automatic fillRandom();
        for (int i = 0; i < 8; i++) blk[i] = 8'($urandom_range(0, 255));
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        readyMode = 0;
        for (int i = 0; i < 8; i++) blk[i] = 8'(8 - i);
        applyStimulus(8, 0);

        blk = '{8'd3, 8'd3, 8'd1, 8'd200, 8'd0, 8'd255, 8'd3, 8'd1};
        applyStimulus(8, 0);

        for (int i = 0; i < 8; i++) blk[i] = 8'(i + 1);
        applyStimulus(8, 0);

        readyMode = 2;
        fillRandom();
        applyStimulus(8, 1);

        readyMode = 0;
        repeat (30) @(posedge clk);
        #1;
        fillRandom();
        applyStimulus(4, 0);
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        for (int i = 0; i < 8; i++) blk[i] = 8'(10 * (i + 1));
        applyStimulus(8, 0);

        readyMode = 1;
        for (int b = 0; b < 20; b++) begin
            fillRandom();
            if (b % 5 == 0) blk[3] = blk[1];
            applyStimulus(8, (b % 3 == 0));
        end

        for (int k = 0; k < 500 && (expQ.size() != 0 || busyQ.size() != 0); k++) @(posedge clk);
        repeat (3) @(posedge clk);
        checkOutput("scoreboard_empty", expQ.size(), 0);
        checkOutput("busy_queue_empty", busyQ.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
